// File: rtl/arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: index width, eot bit position, FSM states.
package arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Index width for n requesters; a single-bit index is kept even for n <= 2.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // The end-of-transaction flag rides in the top bit of each data beat.
  function automatic int eot_bit(input int din);
    return din - 1;
  endfunction

endpackage

// File: rtl/arbiter_rr_pick.sv
// Rotating-priority find-first: returns the first set request at or after ptr, wrapping at NUM_IN.
module rr_pick
  import arbiter_pkg::*;
#(
  parameter int  NUM_IN = 4,
  localparam int IDX_W  = idx_width(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              any
);

  localparam logic [IDX_W:0] NUM_W = (IDX_W+1)'(NUM_IN);

  logic [NUM_IN-1:0] rot;
  logic [IDX_W-1:0]  off;
  logic              found;
  logic [IDX_W:0]    sum;

  // Rotate so that requester ptr lands at bit 0, then take the lowest set bit.
  always_comb begin
    rot   = NUM_IN'({req, req} >> ptr);
    off   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (!found && rot[i]) begin
        off   = IDX_W'(i);
        found = 1'b1;
      end
    end
    sum     = {1'b0, ptr} + {1'b0, off};
    gnt_idx = (sum >= NUM_W) ? IDX_W'(sum - NUM_W) : sum[IDX_W-1:0];
    any     = |req;
  end

endmodule

// File: rtl/arbiter_rr.sv
// N-input round-robin arbiter onto one valid/ready channel, with optional per-transaction lock.
//
//   state  | meaning
//   IDLE   | no owner; grant follows the rotating-priority pick
//   LOCKED | lock_idx owns the channel (stalled beat or open transaction)
module arbiter_rr
  import arbiter_pkg::*;
#(
  parameter int  NUM_IN   = 4,
  parameter int  DIN      = 16,
  parameter int  LOCK_EOT = 1,
  localparam int IDX_W    = idx_width(NUM_IN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_IN-1:0]     din_valid,
  output logic [NUM_IN-1:0]     din_ready,
  input  logic [NUM_IN*DIN-1:0] din_data,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [DIN-1:0]        dout_data,
  output logic [IDX_W-1:0]      dout_idx
);

  localparam int             EOT_BIT = eot_bit(DIN);
  localparam logic [IDX_W:0] NUM_W   = (IDX_W+1)'(NUM_IN);

  arb_state_e       state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0] lock_idx, lock_idx_nxt;
  logic [IDX_W-1:0] pick_idx, grant;
  logic             pick_any, xfer, eot, release_now;

  // Priority moves to the requester just after the one that finished, wrapping at NUM_IN.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    logic [IDX_W:0] s;
    s = {1'b0, i} + (IDX_W+1)'(1);
    return (s == NUM_W) ? '0 : s[IDX_W-1:0];
  endfunction

  rr_pick #(.NUM_IN(NUM_IN)) u_pick (
    .req     (din_valid),
    .ptr     (rr_ptr),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // Zero-latency datapath: grant select, output mux and ready steering.
  always_comb begin
    grant      = (state == LOCKED) ? lock_idx : pick_idx;
    dout_valid = 1'b0;
    if (!rst) begin
      dout_valid = (state == LOCKED) ? din_valid[lock_idx] : pick_any;
    end
    dout_idx         = grant;
    dout_data        = din_data[grant*DIN +: DIN];
    din_ready        = '0;
    din_ready[grant] = dout_ready & dout_valid;
  end

  // Next-state: lock on a stall or an open transaction, release and rotate on the closing beat.
  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    lock_idx_nxt = lock_idx;
    xfer         = dout_valid & dout_ready;
    eot          = dout_data[EOT_BIT];
    release_now  = xfer & ((LOCK_EOT == 0) | eot);
    case (state)
      IDLE: begin
        if (release_now) begin
          rr_ptr_nxt = wrap_inc(grant);
        end else if (dout_valid) begin
          state_nxt    = LOCKED;
          lock_idx_nxt = grant;
        end
      end
      LOCKED: begin
        if (release_now) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = wrap_inc(lock_idx);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      lock_idx <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      lock_idx <= lock_idx_nxt;
    end
  end

endmodule

// File: tb/tb_arbiter_rr.sv
// Bench for arbiter_rr: three instances (4-way locking, 4-way non-locking, 3-way locking),
// directed scenarios plus randomized traffic against an owner/priority reference model.
module tb_arbiter_rr;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  tv [3];
  logic [15:0] td [3][4];
  logic        tr [3];

  logic [2:0]  v_c;
  logic [63:0] pd_a, pd_b;
  logic [47:0] pd_c;
  assign v_c  = tv[2][2:0];
  assign pd_a = {td[0][3], td[0][2], td[0][1], td[0][0]};
  assign pd_b = {td[1][3], td[1][2], td[1][1], td[1][0]};
  assign pd_c = {td[2][2], td[2][1], td[2][0]};

  logic        ov_a, ov_b, ov_c;
  logic [1:0]  oi_a, oi_b, oi_c;
  logic [15:0] od_a, od_b, od_c;
  logic [3:0]  or_a, or_b;
  logic [2:0]  or_c;

  arbiter_rr #(.NUM_IN(4), .DIN(16), .LOCK_EOT(1)) u_a (
    .clk(clk), .rst(rst), .din_valid(tv[0]), .din_ready(or_a), .din_data(pd_a),
    .dout_valid(ov_a), .dout_ready(tr[0]), .dout_data(od_a), .dout_idx(oi_a));
  arbiter_rr #(.NUM_IN(4), .DIN(16), .LOCK_EOT(0)) u_b (
    .clk(clk), .rst(rst), .din_valid(tv[1]), .din_ready(or_b), .din_data(pd_b),
    .dout_valid(ov_b), .dout_ready(tr[1]), .dout_data(od_b), .dout_idx(oi_b));
  arbiter_rr #(.NUM_IN(3), .DIN(16), .LOCK_EOT(1)) u_c (
    .clk(clk), .rst(rst), .din_valid(v_c), .din_ready(or_c), .din_data(pd_c),
    .dout_valid(ov_c), .dout_ready(tr[2]), .dout_data(od_c), .dout_idx(oi_c));

  // Reference model: current owner (-1 = none) and the highest-priority requester.
  int nin [3] = '{4, 4, 3};
  int lk  [3] = '{1, 0, 1};
  int m_ptr [3];
  int m_hold [3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_ptr[k]  = 0;
      m_hold[k] = -1;
    end
  endtask

  // Requester that should be on the output this cycle, or -1 when dout_valid must be low.
  function automatic int mgrant(input int k);
    if (m_hold[k] >= 0) return tv[k][m_hold[k]] ? m_hold[k] : -1;
    for (int j = 0; j < nin[k]; j++) begin
      int i;
      i = (m_ptr[k] + j) % nin[k];
      if (tv[k][i]) return i;
    end
    return -1;
  endfunction

  task automatic model_commit(input int k, input int g);
    if (g < 0) return;
    if (tr[k] && (lk[k] == 0 || td[k][g][15])) begin
      m_hold[k] = -1;
      m_ptr[k]  = (g + 1) % nin[k];
    end else begin
      m_hold[k] = g;
    end
  endtask

  task automatic sample(input int k, output logic v, output int idx,
                        output logic [15:0] dat, output logic [3:0] rd);
    case (k)
      0:       begin v = ov_a; idx = int'(oi_a); dat = od_a; rd = or_a; end
      1:       begin v = ov_b; idx = int'(oi_b); dat = od_b; rd = or_b; end
      default: begin v = ov_c; idx = int'(oi_c); dat = od_c; rd = {1'b0, or_c}; end
    endcase
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 3; k++) begin
      tv[k] = 4'b0000;
      tr[k] = 1'b0;
      for (int i = 0; i < 4; i++) td[k][i] = 16'h0000;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tv[0] = 4'b1111; tv[1] = 4'b1111; tv[2] = 4'b0111;
    tr[0] = 1'b1; tr[1] = 1'b1; tr[2] = 1'b1;
    #2;
    checks++;
    if ({ov_a, or_a, ov_b, or_b, ov_c, or_c} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b%b%b ready=%b/%b/%b, want all zero",
               ov_a, ov_b, ov_c, or_a, or_b, or_c);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    clear_inputs();
    tv[1] = 4'b0100; td[1][2] = 16'h0005; tr[1] = 1'b1;
    @(negedge clk);
    checks++;
    if ({ov_b, oi_b, od_b, or_b} !== {1'b1, 2'd2, 16'h0005, 4'b0100}) begin
      errors++;
      $display("FAIL single_req: got v=%b idx=%0d data=%h rdy=%b, want v=1 idx=2 data=0005 rdy=0100",
               ov_b, oi_b, od_b, or_b);
    end
    model_commit(1, 2);
    @(posedge clk); #1;
    tv[1] = 4'b1111;
    for (int i = 0; i < 4; i++) td[1][i] = 16'h8000 | 16'(i);
    @(negedge clk);
    checks++;
    if ({ov_b, oi_b} !== {1'b1, 2'd3}) begin
      errors++;
      $display("FAIL ptr_after_single: got v=%b idx=%0d, want v=1 idx=3", ov_b, oi_b);
    end
    model_commit(1, 3);
    @(posedge clk); #1;
  endtask

  task automatic test_rotation();
    int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    tv[1] = 4'b1111; tr[1] = 1'b1;
    for (int i = 0; i < 4; i++) td[1][i] = 16'h8000 | 16'(i);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if ({ov_b, oi_b, or_b} !== {1'b1, 2'(exp_seq[c]), 4'(1 << exp_seq[c])}) begin
        errors++;
        $display("FAIL rotation[%0d]: got v=%b idx=%0d rdy=%b, want idx=%0d", c, ov_b, oi_b, or_b, exp_seq[c]);
      end
      model_commit(1, exp_seq[c]);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    do_reset();
    tv[0] = 4'b0010; td[0][1] = 16'h9234; td[0][0] = 16'h8abc; tr[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) tv[0][0] = 1'b1;
      @(negedge clk);
      checks++;
      if ({ov_a, oi_a, od_a, or_a} !== {1'b1, 2'd1, 16'h9234, 4'b0000}) begin
        errors++;
        $display("FAIL stall[%0d]: got v=%b idx=%0d data=%h rdy=%b, want v=1 idx=1 data=9234 rdy=0000",
                 c, ov_a, oi_a, od_a, or_a);
      end
      model_commit(0, 1);
      @(posedge clk); #1;
    end
    tr[0] = 1'b1;
    @(negedge clk);
    checks++;
    if ({ov_a, oi_a, od_a, or_a} !== {1'b1, 2'd1, 16'h9234, 4'b0010}) begin
      errors++;
      $display("FAIL stall_release: got idx=%0d data=%h rdy=%b, want idx=1 data=9234 rdy=0010", oi_a, od_a, or_a);
    end
    model_commit(0, 1);
    @(posedge clk); #1;
    tv[0][1] = 1'b0;
    @(negedge clk);
    checks++;
    if ({ov_a, oi_a, od_a, or_a} !== {1'b1, 2'd0, 16'h8abc, 4'b0001}) begin
      errors++;
      $display("FAIL stall_next: got idx=%0d data=%h rdy=%b, want idx=0 data=8abc rdy=0001", oi_a, od_a, or_a);
    end
    model_commit(0, 0);
    @(posedge clk); #1;
  endtask

  task automatic test_lock();
    logic [15:0] beats [3] = '{16'h0001, 16'h0002, 16'h8003};
    do_reset();
    tv[0] = 4'b1001; td[0][3] = 16'h8333; tr[0] = 1'b1;
    for (int b = 0; b < 3; b++) begin
      td[0][0] = beats[b];
      @(negedge clk);
      checks++;
      if ({ov_a, oi_a, od_a, or_a} !== {1'b1, 2'd0, beats[b], 4'b0001}) begin
        errors++;
        $display("FAIL lock_beat[%0d]: got idx=%0d data=%h rdy=%b, want idx=0 data=%h rdy=0001",
                 b, oi_a, od_a, or_a, beats[b]);
      end
      model_commit(0, 0);
      @(posedge clk); #1;
    end
    tv[0][0] = 1'b0;
    @(negedge clk);
    checks++;
    if ({ov_a, oi_a, od_a, or_a} !== {1'b1, 2'd3, 16'h8333, 4'b1000}) begin
      errors++;
      $display("FAIL lock_next: got idx=%0d data=%h rdy=%b, want idx=3 data=8333 rdy=1000", oi_a, od_a, or_a);
    end
    model_commit(0, 3);
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    int exp_seq [4] = '{0, 1, 2, 0};
    do_reset();
    tv[2] = 4'b0111; tr[2] = 1'b1;
    for (int i = 0; i < 3; i++) td[2][i] = 16'h8000 | 16'(i);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({ov_c, oi_c, or_c} !== {1'b1, 2'(exp_seq[c]), 3'(1 << exp_seq[c])}) begin
        errors++;
        $display("FAIL wrap3[%0d]: got v=%b idx=%0d rdy=%b, want idx=%0d", c, ov_c, oi_c, or_c, exp_seq[c]);
      end
      model_commit(2, exp_seq[c]);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    tv[0] = 4'b0100; td[0][2] = 16'h0022; tr[0] = 1'b1;
    @(negedge clk);
    checks++;
    if ({ov_a, oi_a, od_a, or_a} !== {1'b1, 2'd2, 16'h0022, 4'b0100}) begin
      errors++;
      $display("FAIL midlock_first: got idx=%0d data=%h rdy=%b, want idx=2 data=0022 rdy=0100", oi_a, od_a, or_a);
    end
    model_commit(0, 2);
    @(posedge clk); #1;
    tv[0] = 4'b0101; td[0][2] = 16'h8023; td[0][0] = 16'h8000; tr[0] = 1'b0;
    @(negedge clk);
    checks++;
    if ({ov_a, oi_a, od_a, or_a} !== {1'b1, 2'd2, 16'h8023, 4'b0000}) begin
      errors++;
      $display("FAIL midlock_held: got idx=%0d data=%h rdy=%b, want idx=2 data=8023 rdy=0000", oi_a, od_a, or_a);
    end
    rst = 1'b1;
    tr[0] = 1'b1;
    #1;
    checks++;
    if ({ov_a, or_a} !== 5'd0) begin
      errors++;
      $display("FAIL midlock_in_reset: got v=%b rdy=%b, want v=0 rdy=0000", ov_a, or_a);
    end
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({ov_a, oi_a, od_a, or_a} !== {1'b1, 2'd0, 16'h8000, 4'b0001}) begin
      errors++;
      $display("FAIL midlock_after: got v=%b idx=%0d data=%h rdy=%b, want v=1 idx=0 data=8000 rdy=0001",
               ov_a, oi_a, od_a, or_a);
    end
    model_commit(0, 0);
    @(posedge clk); #1;
  endtask

  task automatic test_random(input int k, input int cycles);
    logic        v;
    int          idx, g, acc;
    logic [15:0] dat;
    logic [3:0]  rd, rd_exp;
    do_reset();
    for (int c = 0; c < cycles; c++) begin
      tr[k] = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      g = mgrant(k);
      sample(k, v, idx, dat, rd);
      rd_exp = (g >= 0 && tr[k]) ? 4'(1 << g) : 4'b0000;
      checks++;
      if (v !== (g >= 0) || rd !== rd_exp) begin
        errors++;
        $display("FAIL rand%0d_valid_ready[%0d]: got v=%b rdy=%b, want v=%b rdy=%b", k, c, v, rd, (g >= 0), rd_exp);
      end
      if (g >= 0) begin
        checks++;
        if (idx !== g || dat !== td[k][g]) begin
          errors++;
          $display("FAIL rand%0d_grant[%0d]: got idx=%0d data=%h, want idx=%0d data=%h", k, c, idx, dat, g, td[k][g]);
        end
      end
      acc = (g >= 0 && tr[k]) ? g : -1;
      model_commit(k, g);
      @(posedge clk); #1;
      for (int i = 0; i < nin[k]; i++) begin
        if (tv[k][i]) begin
          if (i == acc) begin
            tv[k][i] = 1'($urandom_range(0, 1));
            td[k][i] = {($urandom_range(0, 2) == 0), 15'($urandom)};
          end
        end else if ($urandom_range(0, 2) == 0) begin
          tv[k][i] = 1'b1;
          td[k][i] = {($urandom_range(0, 2) == 0), 15'($urandom)};
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_rotation();
    test_stall();
    test_lock();
    test_wrap();
    test_reset_mid_lock();
    test_random(0, 400);
    test_random(1, 400);
    test_random(2, 400);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
